// File: rtl/sobel_edge_filter.sv
// rtl/sobel_edge_filter.sv - 3x3 Sobel edge detector on an RGB565 pixel stream
//
// Ports:
//   iCLK  - pixel clock, all state changes on the rising edge
//   iRST  - asynchronous active-low reset
//   iDVAL - iDATA holds a valid pixel this cycle
//   iSOF  - start of frame, clears the row/column position
//   iDATA - RGB565 pixel (R[15:11], G[10:5], B[4:0])
//   oDATA - 16'hFFFF for an edge pixel, 16'h0000 otherwise
//   oDVAL - oDATA valid, two cycles after the matching iDVAL

module sobel_edge_filter #(
    parameter int         LINE_W = 640,
    parameter logic [7:0] THRESH = 8'd64
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iDVAL,
    input  logic        iSOF,
    input  logic [15:0] iDATA,
    output logic [15:0] oDATA,
    output logic        oDVAL
);

    localparam int         AW       = (LINE_W > 1) ? $clog2(LINE_W) : 1;
    localparam logic [9:0] LAST_COL = 10'(LINE_W - 1);

    logic [9:0]    col;
    logic [9:0]    row;
    logic [7:0]    lb0 [0:LINE_W-1];
    logic [7:0]    lb1 [0:LINE_W-1];
    logic [7:0]    win [0:2][0:2];
    logic          v1;
    logic          border1;

    // Stage 1: luma and current pixel position
    logic [9:0]    luma_sum;
    logic [7:0]    y;
    logic [9:0]    eff_col;
    logic [9:0]    eff_row;
    logic [AW-1:0] addr;
    logic [7:0]    lb0_q;
    logic [7:0]    lb1_q;

    assign luma_sum = {2'b00, iDATA[15:11], 3'b000}
                    + {1'b0,  iDATA[10:5],  3'b000}
                    + {2'b00, iDATA[4:0],   3'b000};
    assign y        = 8'(luma_sum >> 2);

    // A start-of-frame pixel is treated as position (0,0) in its own cycle.
    assign eff_col = iSOF ? 10'd0 : col;
    assign eff_row = iSOF ? 10'd0 : row;
    assign addr    = eff_col[AW-1:0];

    // Combinational read before the write: read-during-write sees old data.
    assign lb0_q = lb0[addr];
    assign lb1_q = lb1[addr];

    always_ff @(posedge iCLK) begin
        if (iDVAL) begin
            lb0[addr] <= y;
            lb1[addr] <= lb0_q;
        end
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            col <= 10'd0;
            row <= 10'd0;
        end else if (iDVAL) begin
            if (eff_col == LAST_COL) begin
                col <= 10'd0;
                row <= (eff_row == 10'd1023) ? eff_row : eff_row + 10'd1;
            end else begin
                col <= eff_col + 10'd1;
                row <= eff_row;
            end
        end else if (iSOF) begin
            col <= 10'd0;
            row <= 10'd0;
        end
    end

    // Window: row 2 / column 2 are newest. Border flag travels with the valid.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win[r][c] <= 8'd0;
                end
            end
            v1      <= 1'b0;
            border1 <= 1'b0;
        end else begin
            v1      <= iDVAL;
            border1 <= (eff_row < 10'd2) || (eff_col < 10'd2);
            if (iDVAL) begin
                for (int r = 0; r < 3; r++) begin
                    win[r][0] <= win[r][1];
                    win[r][1] <= win[r][2];
                end
                win[0][2] <= lb1_q;
                win[1][2] <= lb0_q;
                win[2][2] <= y;
            end
        end
    end

    // Stage 2: gradients in 11-bit two's complement (|G| <= 1000 fits)
    function automatic logic [10:0] ext(input logic [7:0] p);
        return {3'b000, p};
    endfunction

    logic [10:0] gx;
    logic [10:0] gy;
    logic [10:0] ax;
    logic [10:0] ay;
    logic [11:0] mag;
    logic [7:0]  mag8;
    logic        is_edge;

    always_comb begin
        gx = (ext(win[0][2]) + (ext(win[1][2]) << 1) + ext(win[2][2]))
           - (ext(win[0][0]) + (ext(win[1][0]) << 1) + ext(win[2][0]));
        gy = (ext(win[2][0]) + (ext(win[2][1]) << 1) + ext(win[2][2]))
           - (ext(win[0][0]) + (ext(win[0][1]) << 1) + ext(win[0][2]));
        ax      = gx[10] ? (~gx + 11'd1) : gx;
        ay      = gy[10] ? (~gy + 11'd1) : gy;
        mag     = {1'b0, ax} + {1'b0, ay};
        mag8    = (mag > 12'd255) ? 8'hFF : mag[7:0];
        is_edge = (mag8 >= THRESH);
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            oDATA <= 16'h0000;
            oDVAL <= 1'b0;
        end else begin
            oDVAL <= v1;
            oDATA <= (v1 && !border1 && is_edge) ? 16'hFFFF : 16'h0000;
        end
    end

endmodule

// File: doc/sobel_edge_filter.md
SOBEL_EDGE_FILTER -- requirements
Module: sobel_edge_filter

Interface
REQ-001 SHALL have parameter LINE_W, default 640, meaning valid pixels per line (range 4..1024).
REQ-002 SHALL have parameter THRESH, default 8'd64, meaning the edge threshold on gradient magnitude.
REQ-003 SHALL have port iCLK, input, 1 bit: pixel clock; all state changes on its rising edge.
REQ-004 SHALL have port iRST, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port iDVAL, input, 1 bit: iDATA carries a valid pixel this cycle.
REQ-006 SHALL have port iSOF, input, 1 bit: start-of-frame pulse; clears the row/column position.
REQ-007 SHALL have port iDATA, input, 16 bits: RGB565 pixel, R[15:11], G[10:5], B[4:0].
REQ-008 SHALL have port oDATA, output, 16 bits: edge pixel, 16'hFFFF for edge, 16'h0000 otherwise.
REQ-009 SHALL have port oDVAL, output, 1 bit: oDATA valid this cycle.

Function
REQ-010 Stage 1 SHALL compute luma Y[7:0] = ({R,3'b0} + 2*{G,2'b0} + {B,3'b0}) >> 2, using 10-bit intermediate width; maximum Y = 250.
REQ-011 SHALL hold two line buffers, each LINE_W x 8 bits, plus a 3x3 window of 8-bit registers.
REQ-012 On an accepted pixel (iDVAL=1), the window SHALL shift one column: new column = {line buffer 1 output, line buffer 0 output, Y}.
REQ-013 On an accepted pixel, Y SHALL be written into line buffer 0 and line buffer 0's old output into line buffer 1, both at the column address.
REQ-014 With iDVAL=0, the window, line buffers and counters SHALL hold.
REQ-015 Column counter col (10 bits) SHALL increment per accepted pixel and wrap LINE_W-1 -> 0.
REQ-016 On the col wrap, row (10 bits) SHALL increment, saturating at 1023.
REQ-017 iSOF=1 SHALL clear col and row; iSOF and iDVAL in the same cycle SHALL treat that pixel as (row 0, col 0).
REQ-018 Stage 2 SHALL compute signed 11-bit Gx = (P02 + 2P12 + P22) - (P00 + 2P10 + P20) and Gy = (P20 + 2P21 + P22) - (P00 + 2P01 + P02), where Prc is row r, column c, row 2 newest, column 2 newest.
REQ-019 Magnitude SHALL be |Gx| + |Gy|, saturated to 8'd255.
REQ-020 oDATA SHALL be 16'hFFFF when magnitude >= THRESH, else 16'h0000.
REQ-021 For an input pixel at (r, c), the output SHALL represent the window centre (r-1, c-1).
REQ-022 Output SHALL be forced to 16'h0000 when r < 2 or c < 2 (border); oDVAL still asserts.
REQ-023 Latency SHALL be exactly 2 cycles: oDVAL(t+2) = iDVAL(t), and exactly one oDVAL per accepted pixel.
REQ-024 The stage-1/stage-2 pipeline SHALL advance every cycle regardless of iDVAL; valid bits travel with the data.
REQ-025 Line buffers SHALL be inferable as single-clock RAM with read-during-write returning old data.

Reset
REQ-026 While iRST=0: oDATA=16'h0000, oDVAL=0, col=0, row=0, window registers=0, pipeline valid bits=0.
REQ-027 Line-buffer RAM contents SHALL NOT require reset; border forcing (REQ-022) masks stale data.
REQ-028 Reset asserted mid-line SHALL take effect asynchronously; the first pixel after release SHALL be (0,0) without iSOF.

Verification
REQ-029 Flat frame, all pixels 16'h7BEF, LINE_W=8, 4 rows -> every oDVAL pixel 16'h0000; count of oDVAL pulses = 32.
REQ-030 Vertical step, LINE_W=8: cols 0-3 = 16'h0000, cols 4-7 = 16'hFFFF -> rows >= 2: cols 4 and 5 (centres 3, 4) give 16'hFFFF, all others 16'h0000.
REQ-031 Threshold boundary, vertical step 16'h0000 | 16'h2080 (Y=16, magnitude 64) -> 16'hFFFF; repeat with 16'h2060 (Y=14, magnitude 56) -> 16'h0000.
REQ-032 Latency: single iDVAL pulse at cycle t -> oDVAL high only at t+2; iDVAL gapped 1-on/1-off gives the same oDATA sequence as contiguous input.
REQ-033 Reset mid-frame at row 3, col 5: outputs clear immediately; the next two rows after release are output as 16'h0000 border.
REQ-034 iSOF coincident with iDVAL at row 5 -> that pixel and the following row are border (16'h0000).
